dmem_responder: RTL and testbench

//  Memory-side responder for the pipeline's M-stage data port. Accepts one load/store

---
 rtl/dmem_if.sv | 22 ++
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// M-stage data-port bundle between the pipeline (master) and the memory responder (slave).
interface dmem_if;
  logic        memreq;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        err;

  modport master (
    output memreq, memwrite, addr, wdata, be,
    input  rdata, ready, stall, err
  );

  modport slave (
    input  memreq, memwrite, addr, wdata, be,
    output rdata, ready, stall, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: serializes one load/store at a time, inserts WAIT_CYCLES wait
// states, then commits the store or returns load data from an internal byte-writable RAM.
//
// state | meaning
// IDLE  | no request outstanding; memreq accepted and latched here
// WAIT  | counting down wait states, pipeline stalled
// RESP  | one-cycle ready pulse; store committed / load data valid
module dmem_responder #(
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] rdata_q;

  logic        op_write;
  logic [31:0] op_addr, op_wdata;
  logic [3:0]  op_be;
  logic        misaligned;
  logic        enter_resp;
  logic [AW-1:0] widx;
  logic        unused_addr;

  logic [31:0] mem [0:(1<<AW)-1];

  // With zero wait states the RAM access happens on the accepting edge, so the
  // operation must come straight from the bus while still in IDLE.
  always_comb begin
    op_write = lat_write;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    op_be    = lat_be;
    if (state == IDLE) begin
      op_write = bus.memwrite;
      op_addr  = bus.addr;
      op_wdata = bus.wdata;
      op_be    = bus.be;
    end
  end

  assign misaligned  = (op_addr[1:0] != 2'b00);
  assign widx        = op_addr[AW+1:2];
  assign unused_addr = ^op_addr[31:AW+2];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.memreq) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP) && (state != RESP) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_be    <= 4'h0;
      rdata_q   <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.memreq) begin
        lat_write <= bus.memwrite;
        lat_addr  <= bus.addr;
        lat_wdata <= bus.wdata;
        lat_be    <= bus.be;
        cnt       <= WC;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp && !op_write)
        rdata_q <= misaligned ? 32'h0 : mem[widx];
    end
  end

  // RAM is deliberately not reset; enter_resp already masks writes during reset.
  always_ff @(posedge clk) begin
    if (enter_resp && op_write && !misaligned) begin
      for (int i = 0; i < 4; i++)
        if (op_be[i]) mem[widx][8*i +: 8] <= op_wdata[8*i +: 8];
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state == RESP);
  assign bus.err   = (state == RESP) && misaligned;
  assign bus.stall = ((state == IDLE) && bus.memreq) || (state == WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven through one request
// task, checked every cycle against a cycle-count/assoc-array model of the memory port.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus0();
  dmem_if bus1();

  logic [1:0]       t_req, t_wr;
  logic [1:0][31:0] t_addr, t_wdata;
  logic [1:0][3:0]  t_be;
  logic [1:0]       o_stall, o_ready, o_err;
  logic [1:0][31:0] o_rdata;

  assign bus0.memreq = t_req[0];   assign bus1.memreq = t_req[1];
  assign bus0.memwrite = t_wr[0];  assign bus1.memwrite = t_wr[1];
  assign bus0.addr = t_addr[0];    assign bus1.addr = t_addr[1];
  assign bus0.wdata = t_wdata[0];  assign bus1.wdata = t_wdata[1];
  assign bus0.be = t_be[0];        assign bus1.be = t_be[1];
  assign o_stall = {bus1.stall, bus0.stall};
  assign o_ready = {bus1.ready, bus0.ready};
  assign o_err   = {bus1.err, bus0.err};
  assign o_rdata[0] = bus0.rdata;
  assign o_rdata[1] = bus1.rdata;

  dmem_responder #(.AW(10), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  dmem_responder #(.AW(10), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int wc[2] = '{2, 0};
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit running = 1'b0;
  int rdy_cyc[2];
  int last_start[2];

  logic [1:0]       e_stall, e_ready, e_err;
  logic [1:0][31:0] e_rdata;
  logic [31:0]      mm [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
  endtask

  always @(negedge clk) begin
    if (running && !rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("stall%0d", d), 32'(o_stall[d]), 32'(e_stall[d]));
        chk($sformatf("ready%0d", d), 32'(o_ready[d]), 32'(e_ready[d]));
        chk($sformatf("err%0d", d),   32'(o_err[d]),   32'(e_err[d]));
        chk($sformatf("rdata%0d", d), o_rdata[d], e_rdata[d]);
        if (o_ready[d]) rdy_cyc[d] = cyc;
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that ends the response.
  task automatic do_req(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b);
    int key;
    logic [31:0] v;
    key = d * 1024 + int'(a[11:2]);
    last_start[d] = cyc;
    t_req[d] = 1'b1; t_wr[d] = w; t_addr[d] = a; t_wdata[d] = wd; t_be[d] = b;
    e_stall[d] = 1'b1;
    repeat (wc[d]) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    e_stall[d] = 1'b0;
    e_ready[d] = 1'b1;
    e_err[d]   = (a[1:0] != 2'b00);
    if (a[1:0] == 2'b00) begin
      if (w) begin
        v = mm.exists(key) ? mm[key] : 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = wd[8*i +: 8];
        mm[key] = v;
      end else begin
        e_rdata[d] = mm[key];
      end
    end else if (!w) begin
      e_rdata[d] = 32'h0;
    end
    @(posedge clk); #1;
    t_req[d] = 1'b0; e_ready[d] = 1'b0; e_err[d] = 1'b0;
    t_addr[d] = $urandom; t_wdata[d] = $urandom; t_wr[d] = 1'($urandom); t_be[d] = 4'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        t_addr[d] = $urandom; t_wdata[d] = $urandom;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int w;
    t_req = '0; t_wr = '0; t_addr = '0; t_wdata = '0; t_be = '0;
    e_stall = '0; e_ready = '0; e_err = '0; e_rdata = '0;
    rdy_cyc = '{0, 0}; last_start = '{0, 0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    running = 1'b1;
    @(negedge clk);
    chk("reset_rdata0", o_rdata[0], 32'h0);
    chk("reset_stall0", 32'(o_stall[0]), 32'h0);
    @(posedge clk); #1;

    // Test 1: store then load, 2 wait states
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("t1_store_latency", 32'(rdy_cyc[0] - last_start[0]), 32'd3);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("t1_load_lit", o_rdata[0], 32'hDEADBEEF);

    // Test 2: byte enables
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("t2_be_lit", o_rdata[0], 32'h11BB33DD);

    // Test 4: misaligned store leaves word intact, misaligned load returns 0
    do_req(0, 1'b1, 32'h22, 32'h55555555, 4'hF);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("t4_word_intact_lit", o_rdata[0], 32'h11BB33DD);
    do_req(0, 1'b0, 32'h23, 32'h0, 4'h0);
    chk("t4_misaligned_load_lit", o_rdata[0], 32'h0);

    // Test 3: zero wait states, back-to-back
    do_req(1, 1'b1, 32'h8, 32'h0BADCAFE, 4'hF);
    do_req(1, 1'b0, 32'h8, 32'h0, 4'h0);
    chk("t3_latency", 32'(rdy_cyc[1] - last_start[1]), 32'd1);
    chk("t3_load_lit", o_rdata[1], 32'h0BADCAFE);
    do_req(1, 1'b0, 32'h8, 32'h0, 4'h0);
    do_req(1, 1'b0, 32'h8, 32'h0, 4'h0);

    // Test 5: aliasing above AW+1
    do_req(1, 1'b1, 32'h1004, 32'hC0FFEE11, 4'hF);
    do_req(1, 1'b0, 32'h0004, 32'h0, 4'h0);
    chk("t5_alias_lit", o_rdata[1], 32'hC0FFEE11);

    // Test 6: reset during WAIT drops the store
    do_req(0, 1'b1, 32'h40, 32'h0, 4'hF);
    t_req[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 32'h40; t_wdata[0] = 32'hCAFEF00D; t_be[0] = 4'hF;
    e_stall[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    t_req[0] = 1'b0; e_stall[0] = 1'b0; e_rdata = '0;
    idle(4);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("t6_dropped_store_lit", o_rdata[0], 32'h0);

    // Random traffic over preinitialised words 0..16 with aliasing and misalignment
    for (int d = 0; d < 2; d++)
      for (int k = 0; k <= 16; k++) do_req(d, 1'b1, 32'(k * 4), $urandom, 4'hF);
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        w = $urandom_range(0, 16);
        a = ($urandom & 32'hFFFF_F000) | 32'(w * 4);
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        do_req(d, 1'($urandom), a, $urandom, 4'($urandom));
        idle($urandom_range(0, 2));
      end
    end

    idle(2);
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
